mac_instr_sequencer: RTL and testbench
======================================

Name: mac_instr_sequencer

Overview:
- Front-end scheduler for the matrix-multiply control unit.
- Accepts matrix-op instructions over a valid/ready handshake and range-checks the dimensions.
- Drives MAC_op, the V/U/ITER dimension buses (raw and minus-one forms) and the unified-buffer start address into the control unit, holds them stable for the whole operation, then retires the instruction on done.
- A watchdog aborts an operation that never completes.

Parameters:
- OP_W, 3, opcode width; must match control unit MAC_op_i.
- DIM_W, 8, dimension field width; legal dimension values are 1..128.
- ADDR_W, 12, unified-buffer address width.
- WDT_W, 16, watchdog counter width; timeout after 2^WDT_W-1 busy cycles.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- instr_valid_i  in  1  instruction present
- instr_ready_o  out  1  sequencer accepts instruction this cycle
- instr_op_i  in  OP_W  opcode; 0 = NOP
- instr_v_i  in  DIM_W  V dimension
- instr_u_i  in  DIM_W  U dimension
- instr_iter_i  in  DIM_W  ITER dimension
- instr_addr_i  in  ADDR_W  unified-buffer start read address
- done_i  in  1  control unit done pulse
- MAC_op_o  out  OP_W  to control unit MAC_op_i
- V_dim_o  out  DIM_W  V dimension
- U_dim_o  out  DIM_W  U dimension
- ITER_dim_o  out  DIM_W  ITER dimension
- V_dim1_o  out  DIM_W-1  V_dim-1
- U_dim1_o  out  DIM_W-1  U_dim-1
- ITER_dim1_o  out  DIM_W-1  ITER_dim-1
- ub_start_addr_o  out  ADDR_W  unified-buffer start read address
- busy_o  out  1  operation in flight
- retire_o  out  1  one-cycle pulse per retired instruction
- err_dim_o  out  1  sticky illegal-dimension flag
- err_wdt_o  out  1  sticky watchdog flag
- err_clr_i  in  1  clears both sticky flags

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; MAC_op_o=0; all dimension, dim1 and address outputs =0; instr_ready_o=0; busy_o, retire_o, err_dim_o, err_wdt_o=0; watchdog counter=0.
- States: IDLE, LAUNCH, RUN, RETIRE.
- IDLE:
  - instr_ready_o=1.
  - Accept when instr_valid_i&&instr_ready_o; all fields are registered.
  - NOP: no issue; retire_o pulses the next cycle; state stays IDLE.
  - Any dimension 0 or >128: dropped; err_dim_o set next cycle; retire_o pulses; state stays IDLE.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle):
  - Dimension, dim1 and address outputs are driven from the latched fields.
  - MAC_op_o still 0, so the control unit sees stable dimensions before the opcode.
  - busy_o=1. Go to RUN.
- RUN:
  - MAC_op_o = latched opcode; all outputs held constant; watchdog increments each cycle.
  - done_i → RETIRE.
  - Watchdog reaching all-ones without done_i → set err_wdt_o, go to RETIRE.
  - done_i on the same cycle as the watchdog limit: done wins; err_wdt_o stays unchanged.
- RETIRE (1 cycle):
  - MAC_op_o=0; retire_o=1; busy_o=0; watchdog cleared. Go to IDLE.
  - Dimension outputs keep their last values.
- Throughput: a legal instruction accepted at cycle t gives MAC_op_o valid at t+2. The next accept is possible at the cycle after RETIRE.
- done_i outside RUN is ignored.
- dim1 arithmetic: dim-1 truncated to DIM_W-1 bits (128 → 127). Legal dims never wrap.
- err_clr_i on the same cycle as a new error: set wins.
- Reset asserted mid-RUN: all outputs immediately return to reset values and the in-flight instruction is lost. No retire_o.

Optional Feature:
- Macro MAC_SEQ_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_busy_cycles_o, 32 bits: counts cycles in LAUNCH or RUN.
  - perf_retired_o, 16 bits: counts retire_o pulses.
  - Both counters saturate at all-ones, reset to 0, and are not cleared by err_clr_i.
- When undefined, neither the ports nor the counters exist, and the rest of the behaviour is identical.

Test Plan:
- Legal op 3, V=16, U=8, ITER=4, addr=0x040 accepted at cycle t:
  - MAC_op_o=3 at t+2, with V_dim1_o=15, U_dim1_o=7, ITER_dim1_o=3, ub_start_addr_o=0x040.
  - done_i at t+20 → retire_o pulses at t+21; MAC_op_o=0 at t+21.
- NOP accepted → retire_o one cycle later; MAC_op_o never leaves 0; busy_o stays 0.
- V=0, then U=129 → each dropped; err_dim_o=1; MAC_op_o stays 0. err_clr_i → err_dim_o=0 next cycle.
- Back-to-back valid instructions (V=128) → instr_ready_o low from LAUNCH through RETIRE. Second instruction accepted the cycle after RETIRE; V_dim1_o=127.
- No done_i with WDT_W reduced to 4 → err_wdt_o set 15 cycles into RUN, then retire_o pulses. done_i on the limit cycle → err_wdt_o stays 0.
- rst_i low mid-RUN → outputs zero asynchronously; no retire_o. With MAC_SEQ_PERF_CNT_EN defined, two ops of 10 RUN cycles → perf_retired_o=2, perf_busy_cycles_o=22.

Source files
------------

// File: rtl/mac_instr_sequencer_if.sv
// rtl/mac_instr_sequencer_if.sv - instruction, control-unit and status bundle of mac_instr_sequencer
// MAC_SEQ_PERF_CNT_EN adds the perf counter signals to the bundle.
interface mac_instr_sequencer_if #(
  parameter int OP_W   = 3,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 12
);
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [OP_W-1:0]   instr_op_i;
  logic [DIM_W-1:0]  instr_v_i;
  logic [DIM_W-1:0]  instr_u_i;
  logic [DIM_W-1:0]  instr_iter_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              done_i;
  logic [OP_W-1:0]   MAC_op_o;
  logic [DIM_W-1:0]  V_dim_o;
  logic [DIM_W-1:0]  U_dim_o;
  logic [DIM_W-1:0]  ITER_dim_o;
  logic [DIM_W-2:0]  V_dim1_o;
  logic [DIM_W-2:0]  U_dim1_o;
  logic [DIM_W-2:0]  ITER_dim1_o;
  logic [ADDR_W-1:0] ub_start_addr_o;
  logic              busy_o;
  logic              retire_o;
  logic              err_dim_o;
  logic              err_wdt_o;
  logic              err_clr_i;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0]       perf_busy_cycles_o;
  logic [15:0]       perf_retired_o;
`endif

  modport slave (
    input  instr_valid_i, instr_op_i, instr_v_i, instr_u_i, instr_iter_i, instr_addr_i,
           done_i, err_clr_i,
    output instr_ready_o, MAC_op_o, V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o, U_dim1_o,
           ITER_dim1_o, ub_start_addr_o, busy_o, retire_o, err_dim_o, err_wdt_o
`ifdef MAC_SEQ_PERF_CNT_EN
    , output perf_busy_cycles_o, perf_retired_o
`endif
  );

  modport master (
    output instr_valid_i, instr_op_i, instr_v_i, instr_u_i, instr_iter_i, instr_addr_i,
           done_i, err_clr_i,
    input  instr_ready_o, MAC_op_o, V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o, U_dim1_o,
           ITER_dim1_o, ub_start_addr_o, busy_o, retire_o, err_dim_o, err_wdt_o
`ifdef MAC_SEQ_PERF_CNT_EN
    , input perf_busy_cycles_o, perf_retired_o
`endif
  );
endinterface

// File: rtl/mac_instr_sequencer.sv
// rtl/mac_instr_sequencer.sv - matrix-op front-end scheduler with dimension check and watchdog
// Define MAC_SEQ_PERF_CNT_EN to add saturating busy-cycle and retired-instruction counters.
module mac_instr_sequencer #(
  parameter int OP_W   = 3,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 12,
  parameter int WDT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mac_instr_sequencer_if.slave bus
);
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(128);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RETIRE} state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, mac_op_q, mac_op_d;
  logic [DIM_W-1:0]  v_q, u_q, iter_q;
  logic [DIM_W-2:0]  v1_q, u1_q, iter1_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WDT_W-1:0]  wdt_q, wdt_d, wdt_inc;
  logic              ready_q, busy_q, busy_d, retire_q, retire_d;
  logic              err_dim_q, err_wdt_q, set_dim_err, set_wdt_err;
  logic              accept, dims_bad, wdt_hit, load;

  function automatic logic dim_illegal(input logic [DIM_W-1:0] d);
    return (d == '0) || (d > DIM_MAX);
  endfunction

  function automatic logic [DIM_W-2:0] minus_one(input logic [DIM_W-1:0] d);
    return (DIM_W-1)'(d - DIM_W'(1));
  endfunction

  assign accept   = bus.instr_valid_i && ready_q;
  assign dims_bad = dim_illegal(bus.instr_v_i) || dim_illegal(bus.instr_u_i) ||
                    dim_illegal(bus.instr_iter_i);
  assign wdt_inc  = wdt_q + WDT_W'(1);
  // Timeout fires on the RUN cycle whose increment would reach all-ones.
  assign wdt_hit  = &wdt_inc;

  always_comb begin
    state_d     = state_q;
    mac_op_d    = '0;
    busy_d      = 1'b0;
    retire_d    = 1'b0;
    set_dim_err = 1'b0;
    set_wdt_err = 1'b0;
    load        = 1'b0;
    wdt_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.instr_op_i == '0) begin
            retire_d = 1'b1;
          end else if (dims_bad) begin
            set_dim_err = 1'b1;
            retire_d    = 1'b1;
          end else begin
            load    = 1'b1;
            busy_d  = 1'b1;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        busy_d   = 1'b1;
        mac_op_d = op_q;
        state_d  = RUN;
      end
      RUN: begin
        if (bus.done_i) begin
          retire_d = 1'b1;
          state_d  = RETIRE;
        end else if (wdt_hit) begin
          set_wdt_err = 1'b1;
          retire_d    = 1'b1;
          state_d     = RETIRE;
        end else begin
          busy_d   = 1'b1;
          mac_op_d = op_q;
          wdt_d    = wdt_inc;
        end
      end
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      mac_op_q  <= '0;
      v_q       <= '0;
      u_q       <= '0;
      iter_q    <= '0;
      v1_q      <= '0;
      u1_q      <= '0;
      iter1_q   <= '0;
      addr_q    <= '0;
      wdt_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      retire_q  <= 1'b0;
      err_dim_q <= 1'b0;
      err_wdt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mac_op_q  <= mac_op_d;
      wdt_q     <= wdt_d;
      ready_q   <= (state_d == IDLE);
      busy_q    <= busy_d;
      retire_q  <= retire_d;
      err_dim_q <= set_dim_err | (err_dim_q & ~bus.err_clr_i);
      err_wdt_q <= set_wdt_err | (err_wdt_q & ~bus.err_clr_i);
      if (load) begin
        op_q    <= bus.instr_op_i;
        v_q     <= bus.instr_v_i;
        u_q     <= bus.instr_u_i;
        iter_q  <= bus.instr_iter_i;
        v1_q    <= minus_one(bus.instr_v_i);
        u1_q    <= minus_one(bus.instr_u_i);
        iter1_q <= minus_one(bus.instr_iter_i);
        addr_q  <= bus.instr_addr_i;
      end
    end
  end

  assign bus.instr_ready_o   = ready_q;
  assign bus.MAC_op_o        = mac_op_q;
  assign bus.V_dim_o         = v_q;
  assign bus.U_dim_o         = u_q;
  assign bus.ITER_dim_o      = iter_q;
  assign bus.V_dim1_o        = v1_q;
  assign bus.U_dim1_o        = u1_q;
  assign bus.ITER_dim1_o     = iter1_q;
  assign bus.ub_start_addr_o = addr_q;
  assign bus.busy_o          = busy_q;
  assign bus.retire_o        = retire_q;
  assign bus.err_dim_o       = err_dim_q;
  assign bus.err_wdt_o       = err_wdt_q;

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0] perf_busy_q;
  logic [15:0] perf_ret_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_busy_q <= '0;
      perf_ret_q  <= '0;
    end else begin
      if ((state_q == LAUNCH || state_q == RUN) && !(&perf_busy_q))
        perf_busy_q <= perf_busy_q + 32'd1;
      if (retire_q && !(&perf_ret_q))
        perf_ret_q <= perf_ret_q + 16'd1;
    end
  end

  assign bus.perf_busy_cycles_o = perf_busy_q;
  assign bus.perf_retired_o     = perf_ret_q;
`else
  // Without the perf option the sequencer carries no counter state.
`endif
endmodule

// File: tb/tb_mac_instr_sequencer.sv
// tb/tb_mac_instr_sequencer.sv - directed and randomized self-checking bench for mac_instr_sequencer
module tb_mac_instr_sequencer;
  localparam int OP_W      = 3;
  localparam int DIM_W     = 8;
  localparam int ADDR_W    = 12;
  localparam int WDT_W     = 5;
  localparam int WDT_LIMIT = (1 << WDT_W) - 1;
  localparam int K_NOP     = 0;
  localparam int K_DROP    = 1;
  localparam int K_LEGAL   = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;
  int   waited;
  int   exp_v, exp_u, exp_it, exp_v1, exp_u1, exp_it1, exp_addr;
  int   exp_err_dim, exp_err_wdt, exp_perf_busy, exp_perf_ret;

  mac_instr_sequencer_if #(.OP_W(OP_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  mac_instr_sequencer #(.OP_W(OP_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .WDT_W(WDT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int op, input int v, input int u, input int it);
    if (op == 0) return K_NOP;
    if (v < 1 || v > 128 || u < 1 || u > 128 || it < 1 || it > 128) return K_DROP;
    return K_LEGAL;
  endfunction

  function automatic int rnd_dim();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return $urandom_range(129, 255);
    return $urandom_range(1, 128);
  endfunction

  task automatic model_reset();
    exp_v = 0; exp_u = 0; exp_it = 0; exp_v1 = 0; exp_u1 = 0; exp_it1 = 0; exp_addr = 0;
    exp_err_dim = 0; exp_err_wdt = 0; exp_perf_busy = 0; exp_perf_ret = 0;
  endtask

  task automatic chk_dims(input string tag);
    chk({tag, "_v"},     32'(bus.V_dim_o),         exp_v);
    chk({tag, "_u"},     32'(bus.U_dim_o),         exp_u);
    chk({tag, "_it"},    32'(bus.ITER_dim_o),      exp_it);
    chk({tag, "_v1"},    32'(bus.V_dim1_o),        exp_v1);
    chk({tag, "_u1"},    32'(bus.U_dim1_o),        exp_u1);
    chk({tag, "_it1"},   32'(bus.ITER_dim1_o),     exp_it1);
    chk({tag, "_addr"},  32'(bus.ub_start_addr_o), exp_addr);
  endtask

  task automatic chk_status(input string tag, input int op, input int busy, input int retire,
                            input int ready);
    chk({tag, "_op"},      32'(bus.MAC_op_o),      op);
    chk({tag, "_busy"},    32'(bus.busy_o),        busy);
    chk({tag, "_retire"},  32'(bus.retire_o),      retire);
    chk({tag, "_ready"},   32'(bus.instr_ready_o), ready);
    chk({tag, "_err_dim"}, 32'(bus.err_dim_o),     exp_err_dim);
    chk({tag, "_err_wdt"}, 32'(bus.err_wdt_o),     exp_err_wdt);
  endtask

  // Presents one instruction at a negedge and follows it to its retire cycle.
  task automatic issue(input int op, input int v, input int u, input int it, input int addr,
                       input int done_at, input bit clr, output int wait_cycles);
    int kind, run_len;
    bus.instr_op_i    = OP_W'(op);
    bus.instr_v_i     = DIM_W'(v);
    bus.instr_u_i     = DIM_W'(u);
    bus.instr_iter_i  = DIM_W'(it);
    bus.instr_addr_i  = ADDR_W'(addr);
    bus.instr_valid_i = 1'b1;
    bus.err_clr_i     = clr;
    wait_cycles = 0;
    while (bus.instr_ready_o !== 1'b1 && wait_cycles < 8) begin
      @(negedge clk_i);
      wait_cycles++;
    end
    chk("accept_ready", 32'(bus.instr_ready_o), 1);
    @(negedge clk_i);
    bus.instr_valid_i = 1'b0;
    bus.err_clr_i     = 1'b0;
    kind = classify(op, v, u, it);
    if (clr) begin
      exp_err_dim = 0;
      exp_err_wdt = 0;
    end
    if (kind == K_DROP) exp_err_dim = 1;
    if (kind != K_LEGAL) begin
      exp_perf_ret++;
      chk_status("nolaunch", 0, 0, 1, 1);
      chk_dims("nolaunch");
      return;
    end
    exp_v = v; exp_u = u; exp_it = it; exp_addr = addr;
    exp_v1 = (v - 1) % 128; exp_u1 = (u - 1) % 128; exp_it1 = (it - 1) % 128;
    chk_status("launch", 0, 1, 0, 0);
    chk_dims("launch");
    bus.done_i = 1'b1;
    @(negedge clk_i);
    bus.done_i = 1'b0;
    run_len = (done_at >= 1 && done_at <= WDT_LIMIT) ? done_at : WDT_LIMIT;
    for (int c = 1; c <= run_len; c++) begin
      chk("run_op", 32'(bus.MAC_op_o), op);
      chk("run_busy", 32'(bus.busy_o), 1);
      if (c == run_len) chk_dims("run");
      if (c == done_at) bus.done_i = 1'b1;
      @(negedge clk_i);
      bus.done_i = 1'b0;
    end
    if (done_at != run_len) exp_err_wdt = 1;
    exp_perf_ret++;
    exp_perf_busy += 1 + run_len;
    chk_status("retire", 0, 0, 1, 0);
    chk_dims("retire");
  endtask

  task automatic clear_errors();
    bus.err_clr_i = 1'b1;
    @(negedge clk_i);
    bus.err_clr_i = 1'b0;
    exp_err_dim = 0;
    exp_err_wdt = 0;
    chk("clr_err_dim", 32'(bus.err_dim_o), 0);
    chk("clr_err_wdt", 32'(bus.err_wdt_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running, expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    bus.instr_valid_i = 1'b0;
    bus.instr_op_i    = '0;
    bus.instr_v_i     = '0;
    bus.instr_u_i     = '0;
    bus.instr_iter_i  = '0;
    bus.instr_addr_i  = '0;
    bus.done_i        = 1'b0;
    bus.err_clr_i     = 1'b0;
    rst_i             = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk_status("reset", 0, 0, 0, 0);
    chk_dims("reset");
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset_ready", 32'(bus.instr_ready_o), 1);

    // Reference op: done in the 19th RUN cycle, i.e. accept t, done t+20, retire t+21.
    issue(3, 16, 8, 4, 'h040, 19, 1'b0, waited);
    issue(0, 5, 5, 5, 'h123, 1, 1'b0, waited);
    chk("accept_after_retire", waited, 1);
    issue(2, 0, 3, 3, 'h055, 1, 1'b0, waited);
    chk("accept_after_nop", waited, 0);
    issue(5, 10, 129, 2, 'h066, 1, 1'b0, waited);
    clear_errors();
    issue(1, 4, 4, 200, 'h007, 1, 1'b1, waited);
    clear_errors();

    issue(4, 128, 1, 128, 'hfff, 3, 1'b0, waited);
    issue(6, 128, 2, 1, 'h001, 2, 1'b0, waited);
    chk("back_to_back_wait", waited, 1);

    issue(7, 1, 1, 1, 'h010, 0, 1'b0, waited);
    clear_errors();
    issue(7, 2, 2, 2, 'h020, WDT_LIMIT, 1'b0, waited);

    for (int n = 0; n < 24; n++) begin
      int op, v, u, it, d;
      op = $urandom_range(0, 7);
      v  = rnd_dim();
      u  = rnd_dim();
      it = rnd_dim();
      d  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      issue(op, v, u, it, $urandom_range(0, 4095), d, $urandom_range(0, 3) == 0, waited);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

`ifdef MAC_SEQ_PERF_CNT_EN
    @(negedge clk_i);
    chk("perf_busy_model", bus.perf_busy_cycles_o, exp_perf_busy);
    chk("perf_retired_model", 32'(bus.perf_retired_o), exp_perf_ret);
`endif

    // Asynchronous reset two cycles into RUN.
    chk("midrun_ready", 32'(bus.instr_ready_o), 1);
    bus.instr_op_i    = 3'd3;
    bus.instr_v_i     = 8'd20;
    bus.instr_u_i     = 8'd20;
    bus.instr_iter_i  = 8'd20;
    bus.instr_addr_i  = 12'h0aa;
    bus.instr_valid_i = 1'b1;
    @(negedge clk_i);
    bus.instr_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("midrun_op", 32'(bus.MAC_op_o), 3);
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    chk_status("async_reset", 0, 0, 0, 0);
    chk_dims("async_reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("reset_hold_retire", 32'(bus.retire_o), 0);
    @(negedge clk_i);
    chk_status("after_reset", 0, 0, 0, 1);

    issue(3, 10, 10, 10, 'h100, 10, 1'b0, waited);
    issue(3, 12, 12, 12, 'h200, 10, 1'b0, waited);
    @(negedge clk_i);
`ifdef MAC_SEQ_PERF_CNT_EN
    chk("perf_retired_two_ops", 32'(bus.perf_retired_o), 2);
    chk("perf_busy_two_ops", bus.perf_busy_cycles_o, 22);
`endif
    chk_status("final", 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
